// File: rtl/icache_param_pkg.sv
// Shared types and address-geometry helpers for the parametrised direct-mapped icache.
package icache_param_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    function automatic int woff_bits(input int blkwords);
        return $clog2(blkwords);
    endfunction

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int sets, input int blkwords);
        return 30 - $clog2(blkwords) - $clog2(sets);
    endfunction

    // A zero-width field still needs a one-bit carrier signal.
    function automatic int field_w(input int n);
        return (n > 0) ? n : 1;
    endfunction

endpackage

// File: rtl/icache_param_if.sv
// Datapath-side fetch port and memory-side refill port of the icache.
// Fetch: imemREN asks for the word at imemaddr; ihit marks imemload valid that cycle.
// Refill: iREN holds iaddr stable; a beat transfers on a cycle with iREN=1 and iwait=0.
interface icache_dp_if;
    import icache_param_pkg::*;
    logic  imemREN;
    word_t imemaddr;
    logic  inval;
    logic  ihit;
    word_t imemload;

    modport master (output imemREN, imemaddr, inval, input ihit, imemload);
    modport slave  (input imemREN, imemaddr, inval, output ihit, imemload);
endinterface

interface icache_mem_if;
    import icache_param_pkg::*;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport master (output iREN, iaddr, input iwait, iload);
    modport slave  (input iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/icache_param_data_array.sv
// SETS x BLKWORDS instruction word storage: combinational read, synchronous write.
module icache_data_array
    import icache_param_pkg::*;
#(
    parameter int SETS     = 16,
    parameter int BLKWORDS = 2,
    parameter int IDXW     = idx_bits(SETS),
    parameter int WOFF     = woff_bits(BLKWORDS),
    parameter int WOFFW    = field_w(WOFF)
) (
    input  logic             clk,
    input  logic [IDXW-1:0]  rd_idx_i,
    input  logic [WOFFW-1:0] rd_woff_i,
    output word_t            rd_data_o,
    input  logic             we_i,
    input  logic [IDXW-1:0]  wr_idx_i,
    input  logic [WOFFW-1:0] wr_woff_i,
    input  word_t            wr_data_i
);
    localparam int ADDR_W = IDXW + WOFF;

    word_t             mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] rd_a;
    logic [ADDR_W-1:0] wr_a;

    generate
        if (WOFF == 0) begin : g_one_word
            logic unused_woff;
            assign unused_woff = ^{rd_woff_i, wr_woff_i};
            assign rd_a = rd_idx_i;
            assign wr_a = wr_idx_i;
        end else begin : g_multi_word
            assign rd_a = {rd_idx_i, rd_woff_i};
            assign wr_a = {wr_idx_i, wr_woff_i};
        end
    endgenerate

    assign rd_data_o = mem_q[rd_a];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[wr_a] <= wr_data_i;
    end

endmodule

// File: rtl/icache_param.sv
// Direct-mapped blocking icache with burst refill, global invalidate and hit/miss counters.
module icache_param
    import icache_param_pkg::*;
#(
    parameter int SETS     = 16,
    parameter int BLKWORDS = 2,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    icache_dp_if.slave       dp,
    icache_mem_if.master     mem,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output state_t           dbg_state_o
);
    localparam int WOFF  = woff_bits(BLKWORDS);
    localparam int WOFFW = field_w(WOFF);
    localparam int IDXW  = idx_bits(SETS);
    localparam int TAGW  = tag_bits(SETS, BLKWORDS);

    state_t           state_q;
    logic [WOFFW-1:0] wcnt_q;
    logic [TAGW-1:0]  fill_tag_q;
    logic [IDXW-1:0]  fill_idx_q;
    logic [SETS-1:0]  valid_q;
    logic [TAGW-1:0]  tag_q [SETS];
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    logic [TAGW-1:0]  req_tag;
    logic [IDXW-1:0]  req_idx;
    logic [WOFFW-1:0] req_woff;
    logic             hit;
    logic             fill_we;
    logic             last_word;
    word_t            rd_data;
    word_t            fill_base;
    logic             unused_byte_off;

    assign req_tag         = dp.imemaddr[31 -: TAGW];
    assign req_idx         = dp.imemaddr[2+WOFF +: IDXW];
    assign req_woff        = dp.imemaddr[2 +: WOFFW] & WOFFW'(BLKWORDS - 1);
    assign unused_byte_off = ^dp.imemaddr[1:0];

    assign hit = (state_q == IDLE) && dp.imemREN && valid_q[req_idx]
                 && (tag_q[req_idx] == req_tag) && !dp.inval;

    assign last_word = (wcnt_q == WOFFW'(BLKWORDS - 1));
    assign fill_we   = (state_q == FILL) && !mem.iwait && !dp.inval;

    icache_data_array #(
        .SETS     (SETS),
        .BLKWORDS (BLKWORDS)
    ) u_data (
        .clk       (CLK),
        .rd_idx_i  (req_idx),
        .rd_woff_i (req_woff),
        .rd_data_o (rd_data),
        .we_i      (fill_we),
        .wr_idx_i  (fill_idx_q),
        .wr_woff_i (wcnt_q),
        .wr_data_i (mem.iload)
    );

    assign dp.ihit     = hit;
    assign dp.imemload = hit ? rd_data : '0;

    // Refill address comes only from latched state, never from imemaddr.
    assign fill_base = {fill_tag_q, fill_idx_q, {(WOFF + 2){1'b0}}};
    assign mem.iREN  = (state_q == FILL);
    assign mem.iaddr = (state_q == FILL) ? (fill_base | (word_t'(wcnt_q) << 2)) : '0;

    assign hit_cnt     = hit_cnt_q;
    assign miss_cnt    = miss_cnt_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            case (state_q)
                IDLE: begin
                    if (dp.imemREN && !hit && !dp.inval) begin
                        state_q    <= FILL;
                        fill_tag_q <= req_tag;
                        fill_idx_q <= req_idx;
                        wcnt_q     <= '0;
                        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                    end
                end
                FILL: begin
                    if (dp.inval) begin
                        state_q <= IDLE;
                        wcnt_q  <= '0;
                    end else if (!mem.iwait) begin
                        wcnt_q <= wcnt_q + WOFFW'(1);
                        if (last_word) begin
                            valid_q[fill_idx_q] <= 1'b1;
                            state_q             <= IDLE;
                            wcnt_q              <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Invalidate wins over any valid bit set by a completing fill.
            if (dp.inval) valid_q <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_we && last_word) tag_q[fill_idx_q] <= fill_tag_q;
    end

endmodule

// File: tb/tb_icache_param.sv
// Randomised and directed bench for icache_param against a block-level cache model.
module tb_icache_param;
  import icache_param_pkg::*;

  localparam int SETS     = 16;
  localparam int BLKWORDS = 2;
  localparam int CNT_W    = 16;
  localparam int BLKB     = 4 * BLKWORDS;

  // clock / reset
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  icache_dp_if  dp();
  icache_mem_if mem();
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  state_t           dbg_state;

  icache_param #(.SETS(SETS), .BLKWORDS(BLKWORDS), .CNT_W(CNT_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .dp          (dp),
    .mem         (mem),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt),
    .dbg_state_o (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // backing memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // model: which block each set holds, plus an in-flight refill
  bit               m_valid [SETS];
  int unsigned      m_blk   [SETS];
  bit               m_busy;
  logic [31:0]      m_base;
  int               m_k;
  logic [CNT_W-1:0] m_hits;
  logic [CNT_W-1:0] m_misses;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
    m_busy = 1'b0; m_base = '0; m_k = 0; m_hits = '0; m_misses = '0;
  endtask

  logic             obs_ihit;
  logic             obs_iren;
  logic [31:0]      obs_load;
  logic [31:0]      obs_iaddr;
  logic [CNT_W-1:0] obs_hits;
  logic [CNT_W-1:0] obs_misses;
  logic [31:0]      trace [8];

  // driver + per-cycle compare + model step
  task automatic cycle(input logic ren, input logic [31:0] a, input logic inv, input logic wt);
    logic        e_hit, e_ren;
    logic [31:0] e_load, e_addr;
    int unsigned blk, set;
    @(negedge CLK);
    dp.imemREN  = ren;
    dp.imemaddr = a;
    dp.inval    = inv;
    mem.iwait   = wt;
    mem.iload   = (wt || !mem.iREN) ? $urandom : mem_word(mem.iaddr);
    #1;
    blk = a / BLKB;
    set = blk % SETS;
    if (m_busy) begin
      e_hit = 1'b0; e_load = '0; e_ren = 1'b1; e_addr = m_base + 32'(4 * m_k);
    end else begin
      e_hit  = ren && m_valid[set] && (m_blk[set] == blk) && !inv;
      e_load = e_hit ? mem_word(a & ~32'h3) : 32'h0;
      e_ren  = 1'b0; e_addr = '0;
    end
    obs_ihit = dp.ihit; obs_load = dp.imemload; obs_iren = mem.iREN; obs_iaddr = mem.iaddr;
    obs_hits = hit_cnt; obs_misses = miss_cnt;
    check("ihit", 32'(obs_ihit), 32'(e_hit));
    check("imemload", obs_load, e_load);
    check("iREN", 32'(obs_iren), 32'(e_ren));
    check("iaddr", obs_iaddr, e_addr);
    check("hit_cnt", 32'(obs_hits), 32'(m_hits));
    check("miss_cnt", 32'(obs_misses), 32'(m_misses));
    @(posedge CLK);
    if (m_busy) begin
      if (inv) m_busy = 1'b0;
      else if (!wt) begin
        m_k++;
        if (m_k == BLKWORDS) begin
          m_valid[(m_base / BLKB) % SETS] = 1'b1;
          m_blk[(m_base / BLKB) % SETS]   = m_base / BLKB;
          m_busy = 1'b0;
        end
      end
    end else begin
      if (e_hit) m_hits++;
      if (ren && !e_hit && !inv) begin
        m_busy = 1'b1; m_base = a - (a % BLKB); m_k = 0; m_misses++;
      end
    end
    if (inv) for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
  endtask

  // hold a fetch until ihit; lat = cycles before the hit cycle
  task automatic fetch(input logic [31:0] a, input int first_wait, output int lat);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      cycle(1'b1, a, 1'b0, (n >= 1 && n <= first_wait));
      if (n < 8) trace[n] = obs_iaddr;
      if (obs_ihit) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL fetch_timeout: no ihit for 0x%08h within 40 cycles", a);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    RST = 1'b1;
    dp.imemREN = 1'b0; dp.imemaddr = '0; dp.inval = 1'b0;
    mem.iwait = 1'b0; mem.iload = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;

    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_ihit", 32'(obs_ihit), 32'h0);
    check("rst_imemload", obs_load, 32'h0);
    check("rst_iren", 32'(obs_iren), 32'h0);
    check("rst_iaddr", obs_iaddr, 32'h0);
    check("rst_hits", 32'(obs_hits), 32'h0);
    check("rst_misses", 32'(obs_misses), 32'h0);

    fetch(32'h100, 0, lat);
    check("miss_latency", 32'(lat), 32'd3);
    check("fill_addr0", trace[1], 32'h100);
    check("fill_addr1", trace[2], 32'h104);
    check("miss_data", obs_load, mem_word(32'h100));
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("miss_cnt_1", 32'(obs_misses), 32'd1);
    check("hit_cnt_1", 32'(obs_hits), 32'd1);

    fetch(32'h104, 0, lat);
    check("hit_latency", 32'(lat), 32'd0);
    check("hit_data", obs_load, mem_word(32'h104));
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("hit_cnt_2", 32'(obs_hits), 32'd2);

    fetch(32'h180, 0, lat);
    check("conflict_latency", 32'(lat), 32'd3);
    fetch(32'h100, 0, lat);
    check("refetch_latency", 32'(lat), 32'd3);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("miss_cnt_3", 32'(obs_misses), 32'd3);

    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    fetch(32'h100, 3, lat);
    check("iwait_latency", 32'(lat), 32'd6);
    for (int i = 1; i <= 4; i++) check("iwait_hold", trace[i], 32'h100);
    check("iwait_addr1", trace[5], 32'h104);

    cycle(1'b1, 32'h208, 1'b0, 1'b0);
    cycle(1'b1, 32'h208, 1'b0, 1'b0);
    check("abort_iaddr", obs_iaddr, 32'h208);
    cycle(1'b1, 32'h208, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("abort_iren", 32'(obs_iren), 32'h0);
    fetch(32'h208, 0, lat);
    check("abort_retry_latency", 32'(lat), 32'd3);
    fetch(32'h100, 0, lat);
    check("inval_old_latency", 32'(lat), 32'd3);

    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0,
            (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3)),
            $urandom_range(0, 31) == 0,
            $urandom_range(0, 3) == 0);
    end

    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h300, 1'b0, 1'b0);
    @(negedge CLK);
    dp.imemREN = 1'b1; dp.imemaddr = 32'h300; dp.inval = 1'b0; mem.iwait = 1'b0;
    #1 check("pre_reset_iren", 32'(mem.iREN), 32'h1);
    #1 RST = 1'b1;
    #1;
    check("areset_ihit", 32'(dp.ihit), 32'h0);
    check("areset_imemload", dp.imemload, 32'h0);
    check("areset_iren", 32'(mem.iREN), 32'h0);
    check("areset_iaddr", mem.iaddr, 32'h0);
    check("areset_hits", 32'(hit_cnt), 32'h0);
    check("areset_misses", 32'(miss_cnt), 32'h0);
    @(posedge CLK);
    #2 RST = 1'b0;
    dp.imemREN = 1'b0;
    model_reset();
    fetch(32'h100, 0, lat);
    check("post_reset_latency", 32'(lat), 32'd3);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("post_reset_misses", 32'(obs_misses), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_param.md
# icache_param

Parametrised, direct-mapped, blocking instruction cache with multi-word blocks, global invalidate and hit/miss counters. It serves the datapath's icache port (imemREN, imemaddr → ihit, imemload) and fills from the memory-controller instruction port (iREN, iaddr → iwait, iload). It generalises the fixed one-word-block icache by making set count and block size parameters, and by adding burst fill, invalidate and performance counters.

## Interface
- SETS, 16: number of sets; power of 2, ≥2.
- BLKWORDS, 2: words per block; power of 2, ≥1.
- CNT_W, 16: width of the hit/miss counters.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  fetched word valid this cycle.
- imemload  out  32  fetched instruction.
- inval  in  1  invalidate all sets, single-cycle pulse.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iwait  in  1  memory not ready; iload is valid when iwait=0 and iREN=1.
- iload  in  32  memory read data.
- hit_cnt  out  CNT_W  number of hits.
- miss_cnt  out  CNT_W  number of misses.

## Operation
- Address split: [1:0] byte offset; WOFF=log2(BLKWORDS) word-offset bits [WOFF+1:2]; IDX=log2(SETS) index bits above that; tag is the remaining upper bits.
- Per set: valid bit, tag, BLKWORDS data words.
- FSM states are IDLE and FILL.
- IDLE: hit = imemREN & valid[idx] & (tag[idx]==addr tag) & !inval.
  - ihit=hit; imemload = the selected word on a hit, else 0.
  - On a miss with imemREN=1 and inval=0, latch the block base address (tag, index), set wcnt=0, and go to FILL.
- FILL: iREN=1; iaddr={latched tag, latched index, wcnt, 2'b00}; ihit=0; imemload=0.
  - When iwait=0, write iload into word wcnt of the latched set and increment wcnt.
  - When wcnt==BLKWORDS-1 and iwait=0, also write the tag, set valid, and return to IDLE.
- Changes to imemaddr during FILL are ignored; the latched block always completes. The re-lookup in IDLE uses the current imemaddr.
- inval:
  - In any state, clears all valid bits at the next edge.
  - In FILL it also aborts the fill: go to IDLE, the partial block stays invalid, and wcnt resets to 0.
  - In IDLE, inval forces ihit=0 and no miss is started that cycle.
- Counters:
  - hit_cnt increments on every ihit cycle.
  - miss_cnt increments once per IDLE→FILL transition.
  - Both wrap modulo 2^CNT_W and are not cleared by inval.
- Reset: all valid bits 0, state IDLE, wcnt 0, counters 0. Outputs then read ihit=0, imemload=0, iREN=0, iaddr=0. Tag and data storage need not be reset.

## Timing
- Hit: combinational, same cycle as the request. Zero-latency lookup.
- Miss, with iwait=0 throughout:
  - cycle 0: miss detected.
  - cycles 1..BLKWORDS: FILL, one word per cycle.
  - cycle BLKWORDS+1: IDLE, ihit=1.
- Each iwait=1 cycle adds one cycle. iaddr is held stable while iwait=1.
- iREN and iaddr are registered-state decodes with no combinational path from imemaddr.
- Data written at an edge is readable as a hit in the following cycle.

## Structure
- cpu_types_pkg supplies word_t.
- New icache_pkg holds the state enum (IDLE, FILL) and helper functions for index, tag and offset widths derived from SETS/BLKWORDS.
- Sub-module icache_data_array: SETS×BLKWORDS word storage, with one combinational read port (idx, woff) and one synchronous write port (idx, woff, we, wdata).
- Tags, valid bits, FSM and counters stay in the top level.

## Test plan
- Reset, then fetch 0x00000100 (SETS=16, BLKWORDS=2, iwait=0):
  - iREN is high for 2 cycles with iaddr 0x100 then 0x104.
  - ihit=1 on the third cycle after the request.
  - miss_cnt=1.
- Then fetch 0x00000104: ihit=1 in the same cycle with the word loaded from 0x104; hit_cnt increments.
- Conflict: fetch 0x00000180 (same index 0, tag 3). Expect a miss and refill; afterwards 0x100 misses again and miss_cnt=3.
- Apply iwait=1 for 3 cycles on the first fill word: iaddr holds 0x100 and the hit arrives 3 cycles later than in the first scenario.
- Pulse inval mid-fill after the first word:
  - FSM returns to IDLE with iREN=0 next cycle.
  - The retried fetch misses.
  - A previously valid block also misses.
- Assert RST mid-fill: all outputs go to their reset values immediately (asynchronous), counters read 0, and the next fetch misses.
